y86_mem_port_arbiter: RTL and testbench

//  Shares the single-ported Y86 memory between fetch (I-side, read-only) and memory stage (D-side, rd/wr).

---
 rtl/y86_mem_port_arbiter.sv | 87 ++++++++
 tb/tb_y86_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_port_arbiter.sv
// y86_mem_port_arbiter: shares the single-ported Y86 memory between fetch (I) and memory stage (D)
module y86_mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_done_o,
  output logic        i_stall_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        d_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        timeout_o
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;
  logic owner_d, grant_d, grant_i, expire;
  logic [SW-1:0] streak;
  logic [7:0] cnt;
  // D wins unless it has starved a pending fetch for MAX_D_STREAK grants
  assign grant_d = d_req_i && (streak < SW'(MAX_D_STREAK) || !i_req_i);
  assign grant_i = i_req_i && !grant_d;
  assign expire = !mem_ack_i && cnt == 8'(TIMEOUT_CYC - 1);
  assign i_stall_o = i_req_i && !i_done_o;
  assign d_stall_o = d_req_i && !d_done_o;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (grant_d || grant_i ? BUSY : IDLE) :
                state == BUSY ? (mem_ack_i || expire ? RESP : BUSY) : IDLE;
  end
  always_comb begin
    i_done_o = state == RESP && !owner_d;
    d_done_o = state == RESP && owner_d;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_d     <= 1'b0;
      streak      <= '0;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_rdata_o   <= '0;
      d_rdata_o   <= '0;
      timeout_o   <= 1'b0;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      owner_d     <= grant_d;
      cnt         <= '0;
      mem_req_o   <= 1'b1;
      mem_we_o    <= grant_d && d_we_i;
      mem_addr_o  <= grant_d ? d_addr_i : i_addr_i;
      mem_wdata_o <= grant_d ? d_wdata_i : '0;
      streak      <= grant_i ? '0 : i_req_i ? streak + SW'(1) : streak;
    end else if (state == BUSY) begin
      if (mem_ack_i) begin
        mem_req_o <= 1'b0;
        if (!mem_we_o && owner_d) d_rdata_o <= mem_rdata_i;
        if (!mem_we_o && !owner_d) i_rdata_o <= mem_rdata_i;
      end else if (expire) begin
        mem_req_o <= 1'b0;
        timeout_o <= 1'b1;
        if (owner_d) d_rdata_o <= '0;
        else i_rdata_o <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_y86_mem_port_arbiter.sv
// tb_y86_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_y86_mem_port_arbiter;
  localparam int MAX = 4;
  logic clk = 1'b0, rst_n_i = 1'b1;
  logic i_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] i_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic i_done_o, i_stall_o, d_done_o, d_stall_o, mem_req_o, mem_we_o, timeout_o;
  int n_assert = 0, n_fail = 0;
  int lat = 0, wait_cnt = 0;
  bit never_ack = 0, rnd = 0, busy_seen = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  y86_mem_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_done_o(i_done_o), .i_stall_o(i_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // memory responder: acks after lat wait cycles; unwritten locations read as ~addr
  initial forever begin
    @(negedge clk);
    if (mem_req_o && !mem_ack_i) begin
      if (!busy_seen) begin
        busy_seen = 1;
        wait_cnt = 0;
        if (rnd) lat = $urandom_range(0, 3);
      end
      if (!never_ack && wait_cnt == lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : ~mem_addr_o;
      end else wait_cnt++;
    end else begin
      mem_ack_i = 1'b0;
      busy_seen = 0;
      mem_rdata_i = $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output bit is_d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(i_done_o || d_done_o) && cyc < 600);
    check("done_within_bound", 32'(cyc < 600), 1);
    is_d = d_done_o;
  endtask

  initial begin
    bit is_d, g_i, g_d, ji, jd, prev_mreq, cur_we;
    int cyc, cnt, stall, dones, addr_bad, d_run, i_wait, n_txn;
    logic [31:0] cur_da, cur_wd, cur_ia;
    bit exp3 [6] = '{1, 1, 1, 1, 0, 1};
    #1 rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags", {25'd0, mem_req_o, mem_we_o, timeout_o, i_done_o, d_done_o, i_stall_o, d_stall_o}, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_rdata", i_rdata_o | d_rdata_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk);
    // 1: single fetch read, zero-wait memory
    mem[32'h100] = 32'hDEADBEEF;
    i_req_i = 1'b1; i_addr_i = 32'h100;
    #1 check("t1_stall_n", i_stall_o, 1);
    @(negedge clk);
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_addr", mem_addr_o, 32'h100);
    check("t1_mem_we", mem_we_o, 0);
    check("t1_stall_n1", i_stall_o, 1);
    @(negedge clk);
    check("t1_done", i_done_o, 1);
    check("t1_rdata", i_rdata_o, 32'hDEADBEEF);
    check("t1_stall_done", i_stall_o, 0);
    check("t1_req_drop", mem_req_o, 0);
    i_req_i = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", i_done_o, 0);
    check("t1_rdata_hold", i_rdata_o, 32'hDEADBEEF);
    check("t1_no_timeout", timeout_o, 0);
    // 2: simultaneous requests, D write wins, I then reads it back
    i_req_i = 1'b1; i_addr_i = 32'h200;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h55;
    @(negedge clk);
    check("t2_we", mem_we_o, 1);
    check("t2_addr", mem_addr_o, 32'h200);
    check("t2_wdata", mem_wdata_o, 32'h55);
    @(negedge clk);
    check("t2_d_done", d_done_o, 1);
    check("t2_i_not_done", i_done_o, 0);
    d_req_i = 1'b0; d_we_i = 1'b0;
    wait_done(is_d, cyc);
    check("t2_i_owner", 32'(is_d), 0);
    check("t2_i_rdata", i_rdata_o, 32'h55);
    i_req_i = 1'b0;
    @(negedge clk);
    // 3: streak limit forces a fetch after 4 D grants
    i_req_i = 1'b1; i_addr_i = 32'h108;
    d_req_i = 1'b1; d_addr_i = 32'h300;
    for (int k = 0; k < 6; k++) begin
      wait_done(is_d, cyc);
      check($sformatf("t3_owner%0d", k), 32'(is_d), 32'(exp3[k]));
      if (is_d) d_addr_i = d_addr_i + 4;
      else i_req_i = 1'b0;
    end
    d_req_i = 1'b0;
    @(negedge clk);
    // 4: memory never acks
    never_ack = 1;
    i_req_i = 1'b1; i_addr_i = 32'h10C;
    cnt = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_req_o) cnt++;
    end while (!i_done_o && cyc < 400);
    check("t4_req_cycles", cnt, 255);
    check("t4_done", i_done_o, 1);
    check("t4_rdata", i_rdata_o, 0);
    check("t4_timeout", timeout_o, 1);
    i_req_i = 1'b0; never_ack = 0;
    repeat (2) @(negedge clk);
    check("t4_sticky", timeout_o, 1);
    // 5: asynchronous reset mid-transaction
    lat = 10;
    i_req_i = 1'b1; i_addr_i = 32'h110;
    repeat (3) @(negedge clk);
    check("t5_busy", mem_req_o, 1);
    #2 rst_n_i = 1'b0; i_req_i = 1'b0;
    #1 check("t5_async_req", mem_req_o, 0);
    check("t5_async_timeout", timeout_o, 0);
    check("t5_async_addr", mem_addr_o, 0);
    check("t5_async_drdata", d_rdata_o, 0);
    repeat (2) @(negedge clk);
    check("t5_no_done", {30'd0, i_done_o, d_done_o}, 0);
    rst_n_i = 1'b1; lat = 0;
    mem[32'h114] = 32'hCAFEF00D;
    i_req_i = 1'b1; i_addr_i = 32'h114;
    wait_done(is_d, cyc);
    check("t5_owner", 32'(is_d), 0);
    check("t5_latency", cyc, 2);
    check("t5_rdata", i_rdata_o, 32'hCAFEF00D);
    i_req_i = 1'b0;
    @(negedge clk);
    // 6: D read with 5-cycle memory latency
    lat = 5;
    mem[32'h118] = 32'h600DF00D;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h118;
    stall = 0; dones = 0; addr_bad = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (d_stall_o) stall++;
      if (mem_req_o && mem_addr_o !== 32'h118) addr_bad++;
      if (d_done_o) begin
        dones++;
        check("t6_rdata", d_rdata_o, 32'h600DF00D);
        d_req_i = 1'b0;
      end
      @(negedge clk);
    end
    check("t6_stall_cycles", stall, 7);
    check("t6_done_pulses", dones, 1);
    check("t6_addr_stable", addr_bad, 0);
    // randomized traffic: data routing, priority, streak bound and fetch latency
    rnd = 1; d_run = 0; prev_mreq = 0; i_wait = 0; n_txn = 0; g_i = 0; g_d = 0;
    cur_we = 0; cur_da = '0; cur_wd = '0; cur_ia = '0;
    for (int c = 0; c < 440; c++) begin
      @(negedge clk);
      ji = 0; jd = 0;
      if (mem_req_o && !prev_mreq) begin
        g_i = i_req_i;
        g_d = d_req_i;
      end
      prev_mreq = mem_req_o;
      if (d_done_o) begin
        if (cur_we) ref_mem[cur_da] = cur_wd;
        else check("rnd_d_rdata", d_rdata_o, ref_mem.exists(cur_da) ? ref_mem[cur_da] : ~cur_da);
        if (g_i) d_run++;
        check("rnd_streak", 32'(d_run <= MAX), 1);
        d_req_i = 1'b0; jd = 1; n_txn++;
      end
      if (i_done_o) begin
        check("rnd_i_rdata", i_rdata_o, ref_mem.exists(cur_ia) ? ref_mem[cur_ia] : ~cur_ia);
        check("rnd_priority", 32'(g_d && d_run < MAX), 0);
        check("rnd_i_wait", 32'(i_wait <= 60), 1);
        d_run = 0; i_req_i = 1'b0; ji = 1; n_txn++;
      end
      if (i_req_i) i_wait++;
      if (c < 400 && !i_req_i && !ji && $urandom_range(0, 2) == 0) begin
        cur_ia = 32'h400 + 32'($urandom_range(0, 7)) * 4;
        i_req_i = 1'b1; i_addr_i = cur_ia; i_wait = 0;
      end
      if (c < 400 && !d_req_i && !jd && $urandom_range(0, 2) == 0) begin
        cur_we = 1'($urandom_range(0, 1));
        cur_da = 32'h400 + 32'($urandom_range(0, 7)) * 4;
        cur_wd = $urandom;
        d_req_i = 1'b1; d_we_i = cur_we; d_addr_i = cur_da; d_wdata_i = cur_wd;
      end
    end
    check("rnd_drained", {30'd0, i_req_i, d_req_i}, 0);
    check("rnd_traffic", 32'(n_txn > 20), 1);
    check("rnd_no_timeout", timeout_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
